alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port valid_i, input, 1 bit: an operation request is present.
REQ-004 SHALL have port ready_o, output, 1 bit: the unit can accept a request this cycle.
REQ-005 SHALL have port ALUCtrl_i, input, 4 bits: operation code, as produced by the ALU control decoder.
REQ-006 SHALL have port src1_i, input, 32 bits: operand A (rs).
REQ-007 SHALL have port src2_i, input, 32 bits: operand B (rt or immediate).
REQ-008 SHALL have port shamt_i, input, 5 bits: shift amount for SRA and SLL.
REQ-009 SHALL have port result_o, output, 32 bits: registered result.
REQ-010 SHALL have port zero_o, output, 1 bit: registered flag, asserted when result_o == 0.
REQ-011 SHALL have port valid_o, output, 1 bit: one-cycle pulse marking a new result_o/zero_o.

Function
REQ-012 SHALL accept a request on a rising edge where valid_i=1 and ready_o=1, sampling ALUCtrl_i, src1_i, src2_i and shamt_i on that edge.
REQ-013 SHALL compute these codes (A=src1_i, B=src2_i, all arithmetic modulo 2^32):
- 0000 A&B
- 0001 A|B
- 0010 A+B
- 1000 A+B (load/store address)
- 0110 A-B
- 0111 signed A<B ? 1 : 0
- 0101 unsigned A<B ? 1 : 0
- 0011 A-B (BEQ)
- 1001 (A==B) ? 1 : 0 (BNE, so zero_o=1 means taken)
- 1011 {B[15:0],16'h0}
- 1110 B>>>shamt_i, arithmetic
- 1111 B>>>A[4:0], arithmetic
- 1101 B<<shamt_i
- 0100 low 32 bits of A*B
REQ-014 SHALL produce result_o=0, zero_o=1 and a normal valid_o pulse for any other code.
REQ-015 SHALL implement a state machine with states IDLE and MUL; the state is IDLE out of reset.
REQ-016 IDLE: ready_o=1; an accepted non-0100 code SHALL register its result, drive valid_o=1 for exactly the following cycle, and remain in IDLE.
REQ-017 Back-to-back single-cycle requests SHALL be accepted on consecutive edges, with valid_o high continuously, one result per cycle.
REQ-018 IDLE with an accepted 0100: SHALL load the multiplicand (A), multiplier (B), a zeroed accumulator and iteration counter=0, then enter MUL.
REQ-019 MUL: ready_o=0; valid_i SHALL be ignored; each edge adds (multiplicand << counter) to the accumulator when multiplier[counter]=1, then increments counter.
REQ-020 After the edge that performs iteration 31, the unit SHALL return to IDLE, load the accumulator into result_o, and pulse valid_o for one cycle.
REQ-021 MUL latency SHALL be exactly 32 cycles from the accept edge to the edge that asserts valid_o.
REQ-022 The first edge after a MUL completes SHALL be able to accept a new request.
REQ-023 result_o and zero_o SHALL hold their last values until the next result is produced; valid_o=0 at all other times.
REQ-024 ready_o SHALL be a function of state only, with no combinational path from valid_i.
REQ-025 zero_o SHALL always be computed from the value loaded into result_o, never from an intermediate accumulator value.

Reset
REQ-026 rst_i=0 SHALL immediately force state=IDLE, counter=0, accumulator=0, result_o=0, zero_o=1, valid_o=0 and ready_o=1, independent of clk_i.
REQ-027 Reset asserted during MUL SHALL abandon the multiply with no valid_o pulse; the first rising edge after rst_i returns to 1 SHALL be able to accept a new request.

Verification
REQ-028 ADD 0010, A=0x7FFFFFFF, B=1 -> next cycle result_o=0x80000000, zero_o=0, one-cycle valid_o pulse.
REQ-029 SLT vs SLTIU, A=0xFFFFFFFF, B=1 -> SLT result_o=1; SLTIU result_o=0, zero_o=1.
REQ-030 SRAV 1111, A=4, B=0x80000000 -> result_o=0xF8000000; LUI 1011, B=0x00001234 -> result_o=0x12340000.
REQ-031 MUL 0100, A=0xFFFFFFFF, B=3 -> ready_o=0 for 32 cycles, then result_o=0xFFFFFFFD with valid_o for exactly 1 cycle; valid_i pulses during MUL are ignored.
REQ-032 BEQ 0011 then BNE 1001, both with A=B=5, on consecutive edges -> two consecutive valid_o cycles: zero_o=1, then zero_o=0 with result_o=1.
REQ-033 rst_i low at cycle 10 of a MUL -> outputs immediately at reset values, no valid_o; ADD 2+3 issued after reset release -> result_o=5.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/result bundle for alu_exec_unit. The master issues operations and
// observes results; the slave is the execution unit itself.
interface alu_exec_unit_if;
   logic        valid_i;
   logic        ready_o;
   logic [3:0]  ALUCtrl_i;
   logic [31:0] src1_i;
   logic [31:0] src2_i;
   logic [4:0]  shamt_i;
   logic [31:0] result_o;
   logic        zero_o;
   logic        valid_o;

   modport master (
      output valid_i, ALUCtrl_i, src1_i, src2_i, shamt_i,
      input  ready_o, result_o, zero_o, valid_o
   );

   modport slave (
      input  valid_i, ALUCtrl_i, src1_i, src2_i, shamt_i,
      output ready_o, result_o, zero_o, valid_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit. Most operations complete in one cycle;
// multiply runs as a 32-iteration shift-and-add sequence during which new
// requests are refused.
module alu_exec_unit (
   input  logic           clk_i,
   input  logic           rst_i,
   alu_exec_unit_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        valid_q, valid_d;
   logic [31:0] alu_res;
   logic [31:0] partial;

   // Current shift-and-add term: multiplicand shifted into place when the
   // selected multiplier bit is set.
   assign partial = mplier_q[cnt_q] ? (mcand_q << cnt_q) : 32'd0;

   // Single-cycle datapath; multiply and unknown codes fall to zero here.
   always_comb begin
      alu_res = 32'd0;
      case (bus.ALUCtrl_i)
         4'b0000: alu_res = bus.src1_i & bus.src2_i;
         4'b0001: alu_res = bus.src1_i | bus.src2_i;
         4'b0010: alu_res = bus.src1_i + bus.src2_i;
         4'b1000: alu_res = bus.src1_i + bus.src2_i;
         4'b0110: alu_res = bus.src1_i - bus.src2_i;
         4'b0011: alu_res = bus.src1_i - bus.src2_i;
         4'b0111: alu_res = ($signed(bus.src1_i) < $signed(bus.src2_i)) ? 32'd1 : 32'd0;
         4'b0101: alu_res = (bus.src1_i < bus.src2_i) ? 32'd1 : 32'd0;
         4'b1001: alu_res = (bus.src1_i == bus.src2_i) ? 32'd1 : 32'd0;
         4'b1011: alu_res = {bus.src2_i[15:0], 16'h0000};
         4'b1110: alu_res = $signed(bus.src2_i) >>> bus.shamt_i;
         4'b1111: alu_res = $signed(bus.src2_i) >>> bus.src1_i[4:0];
         4'b1101: alu_res = bus.src2_i << bus.shamt_i;
         default: alu_res = 32'd0;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in MUL, publish on completion.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               if (bus.ALUCtrl_i == 4'b0100) begin
                  mcand_d  = bus.src1_i;
                  mplier_d = bus.src2_i;
                  acc_d    = 32'd0;
                  cnt_d    = 5'd0;
                  state_d  = MUL;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == 32'd0);
                  valid_d  = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d = acc_q + partial;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               // zero flag is derived from the final product only
               state_d  = IDLE;
               result_d = acc_d;
               zero_d   = (acc_d == 32'd0);
               valid_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 5'd0;
         result_q <= 32'd0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.ready_o  = (state_q == IDLE);
   assign bus.result_o = result_q;
   assign bus.zero_o   = zero_q;
   assign bus.valid_o  = valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued when a
// request is driven and popped when the unit reports a result.
module tb_alu_exec_unit;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] r;
   } vec_t;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;
   exp_t exp_q[$];

   alu_exec_unit_if bus();

   alu_exec_unit dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference behaviour of the unit for a single request.
   function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
      logic [63:0] ext;
      logic [31:0] r;
      r = 32'd0;
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010, 4'b1000: r = a + b;
         4'b0110, 4'b0011: r = a - b;
         4'b0111: r = ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
         4'b0101: r = (a < b) ? 32'd1 : 32'd0;
         4'b1001: r = (a == b) ? 32'd1 : 32'd0;
         4'b1011: r = b << 16;
         4'b1110: begin ext = {{32{b[31]}}, b} >> sh;      r = ext[31:0]; end
         4'b1111: begin ext = {{32{b[31]}}, b} >> a[4:0];  r = ext[31:0]; end
         4'b1101: r = b << sh;
         4'b0100: r = a * b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = op;
      bus.src1_i    = a;
      bus.src2_i    = b;
      bus.shamt_i   = sh;
   endtask

   task automatic push_exp(input logic [31:0] r);
      exp_t e;
      e.res  = r;
      e.zero = (r == 32'd0);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      bus.valid_i = 1'b0; bus.ALUCtrl_i = 4'd0; bus.src1_i = 32'd0;
      bus.src2_i = 32'd0; bus.shamt_i = 5'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready_o); else pass_cnt++;
      total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_o); else pass_cnt++;
      total_cnt++; if (bus.result_o !== 32'd0) $display("FAIL reset_result got %h want 0", bus.result_o); else pass_cnt++;
      total_cnt++; if (bus.zero_o !== 1'b1) $display("FAIL reset_zero got %b want 1", bus.zero_o); else pass_cnt++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single_ops();
      vec_t v[15];
      exp_t e;
      v[0]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000};
      v[1]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0};
      v[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000};
      v[3]  = '{4'b1000, 32'h00001000, 32'hFFFFFFFC, 5'd0,  32'h00000FFC};
      v[4]  = '{4'b0110, 32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE};
      v[5]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
      v[6]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
      v[7]  = '{4'b0011, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000};
      v[8]  = '{4'b1001, 32'h00000005, 32'h00000006, 5'd0,  32'h00000000};
      v[9]  = '{4'b1011, 32'h00000000, 32'hABCD1234, 5'd0,  32'h12340000};
      v[10] = '{4'b1110, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000};
      v[11] = '{4'b1111, 32'hFFFFFFE4, 32'h80000000, 5'd0,  32'hF8000000};
      v[12] = '{4'b1101, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000};
      v[13] = '{4'b1010, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000};
      v[14] = '{4'b1100, 32'h12345678, 32'h12345678, 5'd3,  32'h00000000};
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(v[i].op, v[i].a, v[i].b, v[i].sh);
         push_exp(v[i].r);
         @(negedge clk);
         bus.valid_i = 1'b0;
         e = exp_q.pop_front();
         total_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL op%0d_valid got %b want 1", i, bus.valid_o); else pass_cnt++;
         total_cnt++; if (bus.result_o !== e.res) $display("FAIL op%0d_result got %h want %h", i, bus.result_o, e.res); else pass_cnt++;
         total_cnt++; if (bus.zero_o !== e.zero) $display("FAIL op%0d_zero got %b want %b", i, bus.zero_o, e.zero); else pass_cnt++;
         total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL op%0d_ready got %b want 1", i, bus.ready_o); else pass_cnt++;
         @(negedge clk);
         total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL op%0d_pulse got %b want 0", i, bus.valid_o); else pass_cnt++;
         total_cnt++; if (bus.result_o !== e.res) $display("FAIL op%0d_hold got %h want %h", i, bus.result_o, e.res); else pass_cnt++;
         $display("op %b a=%h b=%h sh=%0d -> %h", v[i].op, v[i].a, v[i].b, v[i].sh, bus.result_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops[13] = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0110, 4'b0111, 4'b0101,
                               4'b0011, 4'b1001, 4'b1011, 4'b1110, 4'b1111, 4'b1101};
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  sh;
      exp_t        e;
      int          n;
      n = 22;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = exp_q.pop_front();
            total_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL b2b%0d_valid got %b want 1", i, bus.valid_o); else pass_cnt++;
            total_cnt++; if (bus.result_o !== e.res) $display("FAIL b2b%0d_result got %h want %h", i, bus.result_o, e.res); else pass_cnt++;
            total_cnt++; if (bus.zero_o !== e.zero) $display("FAIL b2b%0d_zero got %b want %b", i, bus.zero_o, e.zero); else pass_cnt++;
            $display("b2b %0d result=%h zero=%b", i, bus.result_o, bus.zero_o);
         end
         if (i < n) begin
            if (i == 0) begin
               op = 4'b0011; a = 32'd5; b = 32'd5; sh = 5'd0;
            end else if (i == 1) begin
               op = 4'b1001; a = 32'd5; b = 32'd5; sh = 5'd0;
            end else begin
               op = ops[$urandom_range(0, 12)];
               a  = $urandom; b = $urandom; sh = 5'($urandom_range(0, 31));
               if (i % 4 == 0) b = a;
            end
            drive(op, a, b, sh);
            push_exp(model_alu(op, a, b, sh));
         end else begin
            bus.valid_i = 1'b0;
         end
      end
      @(negedge clk);
      total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL b2b_end_valid got %b want 0", bus.valid_o); else pass_cnt++;
   endtask

   task automatic test_mul(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   k;
      int   stalled;
      @(negedge clk);
      drive(4'b0100, a, b, 5'd0);
      push_exp(model_alu(4'b0100, a, b, 5'd0));
      k = 0;
      stalled = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (bus.valid_o === 1'b1) break;
         if (bus.ready_o !== 1'b0) stalled++;
         // junk requests while busy must be ignored
         drive(4'b0010, $urandom, $urandom, 5'd0);
         bus.valid_i = k[0];
      end
      bus.valid_i = 1'b0;
      e = exp_q.pop_front();
      total_cnt++; if (k !== 33) $display("FAIL mul_latency got %0d want 33 (40 means timeout)", k); else pass_cnt++;
      total_cnt++; if (stalled !== 0) $display("FAIL mul_busy_ready got %0d ready cycles want 0", stalled); else pass_cnt++;
      total_cnt++; if (bus.result_o !== e.res) $display("FAIL mul_result got %h want %h", bus.result_o, e.res); else pass_cnt++;
      total_cnt++; if (bus.zero_o !== e.zero) $display("FAIL mul_zero got %b want %b", bus.zero_o, e.zero); else pass_cnt++;
      total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL mul_done_ready got %b want 1", bus.ready_o); else pass_cnt++;
      $display("mul a=%h b=%h -> %h after %0d cycles", a, b, bus.result_o, k - 1);
      // immediately follow with a request on the first edge after completion
      drive(4'b0010, 32'd2, 32'd3, 5'd0);
      push_exp(32'd5);
      @(negedge clk);
      bus.valid_i = 1'b0;
      e = exp_q.pop_front();
      total_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL mul_next_valid got %b want 1", bus.valid_o); else pass_cnt++;
      total_cnt++; if (bus.result_o !== e.res) $display("FAIL mul_next_result got %h want %h", bus.result_o, e.res); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL mul_next_pulse got %b want 0", bus.valid_o); else pass_cnt++;
   endtask

   task automatic test_reset_mid_mul();
      exp_t e;
      int   pulses;
      @(negedge clk);
      drive(4'b0100, 32'h0000FFFF, 32'h00010001, 5'd0);
      @(negedge clk);
      bus.valid_i = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL rmul_ready got %b want 1", bus.ready_o); else pass_cnt++;
      total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL rmul_valid got %b want 0", bus.valid_o); else pass_cnt++;
      total_cnt++; if (bus.result_o !== 32'd0) $display("FAIL rmul_result got %h want 0", bus.result_o); else pass_cnt++;
      total_cnt++; if (bus.zero_o !== 1'b1) $display("FAIL rmul_zero got %b want 1", bus.zero_o); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0010, 32'd2, 32'd3, 5'd0);
      push_exp(32'd5);
      @(negedge clk);
      bus.valid_i = 1'b0;
      e = exp_q.pop_front();
      total_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL rmul_add_valid got %b want 1", bus.valid_o); else pass_cnt++;
      total_cnt++; if (bus.result_o !== e.res) $display("FAIL rmul_add_result got %h want %h", bus.result_o, e.res); else pass_cnt++;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.valid_o === 1'b1) pulses++;
      end
      total_cnt++; if (pulses !== 0) $display("FAIL rmul_stale got %0d pulses want 0", pulses); else pass_cnt++;
      $display("reset during mul: add result=%h", e.res);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_single_ops();
      test_back_to_back();
      test_mul(32'hFFFFFFFF, 32'h00000003);
      test_mul($urandom, $urandom);
      test_mul(32'h00000000, $urandom);
      test_reset_mid_mul();
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
